// File: rtl/mul32_seq.sv
// Sequential 32x32->64 multiplier controller driving one registered 18x18
// signed DSP multiplier. Four 16-bit partial products are issued one per
// cycle and accumulated into a 64-bit result. Covers MUL/MULH/MULHSU/MULHU
// signedness combinations.

// Single-cycle 18x18 signed multiplier with registered output.
module mult18x18_1c (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [17:0] a,
  input  logic [17:0] b,
  output logic [35:0] p
);

  logic signed [35:0] ax;
  logic signed [35:0] bx;

  assign ax = {{18{a[17]}}, a};
  assign bx = {{18{b[17]}}, b};

  // Register the signed product when enabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      p <= '0;
    end else if (en) begin
      p <= ax * bx;
    end
  end

endmodule

module mul32_seq #(
  parameter int ZERO_SKIP = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        kill,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        signed_a,
  input  logic        signed_b,
  output logic        busy,
  output logic        done,
  output logic [63:0] p
);

  typedef enum logic [2:0] {
    IDLE, MUL0, MUL1, MUL2, MUL3, DRAIN, ZERO, DONE
  } state_t;

  state_t      state;
  logic [31:0] a_r;
  logic [31:0] b_r;
  logic        sa_r;
  logic        sb_r;
  logic [63:0] acc;

  logic [17:0] al;
  logic [17:0] ah;
  logic [17:0] bl;
  logic [17:0] bh;
  logic [17:0] dsp_a;
  logic [17:0] dsp_b;
  logic [35:0] dsp_p;
  logic        dsp_en;
  logic        add_en;
  logic [63:0] prod_ext;
  logic [63:0] addend;
  logic        zero_op;

  // Low halves are always unsigned; high halves carry the operand sign.
  assign al = {2'b00, a_r[15:0]};
  assign ah = {{2{sa_r & a_r[31]}}, a_r[31:16]};
  assign bl = {2'b00, b_r[15:0]};
  assign bh = {{2{sb_r & b_r[31]}}, b_r[31:16]};

  assign prod_ext = {{28{dsp_p[35]}}, dsp_p};
  assign zero_op  = (ZERO_SKIP != 0) && ((a == '0) || (b == '0));

  mult18x18_1c u_dsp (
    .clk (clk),
    .rst (1'b0),
    .en  (dsp_en),
    .a   (dsp_a),
    .b   (dsp_b),
    .p   (dsp_p)
  );

  // Operand select for the issue slot and shifted addend for the product
  // issued one cycle earlier (state k+1 accumulates pair k).
  always_comb begin
    dsp_en = 1'b0;
    dsp_a  = al;
    dsp_b  = bl;
    add_en = 1'b0;
    addend = prod_ext;
    case (state)
      MUL0: begin
        dsp_en = 1'b1;
      end
      MUL1: begin
        dsp_en = 1'b1;
        dsp_b  = bh;
        add_en = 1'b1;
      end
      MUL2: begin
        dsp_en = 1'b1;
        dsp_a  = ah;
        add_en = 1'b1;
        addend = prod_ext << 16;
      end
      MUL3: begin
        dsp_en = 1'b1;
        dsp_a  = ah;
        dsp_b  = bh;
        add_en = 1'b1;
        addend = prod_ext << 16;
      end
      DRAIN: begin
        add_en = 1'b1;
        addend = prod_ext << 32;
      end
      default: ;
    endcase
  end

  // Control FSM, accumulator and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      p     <= '0;
      acc   <= '0;
      a_r   <= '0;
      b_r   <= '0;
      sa_r  <= 1'b0;
      sb_r  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          a_r   <= a;
          b_r   <= b;
          sa_r  <= signed_a;
          sb_r  <= signed_b;
          acc   <= '0;
          busy  <= 1'b1;
          state <= zero_op ? ZERO : MUL0;
        end
      end else if (kill && (state != DONE)) begin
        // Abort: the in-flight DSP product is simply never accumulated.
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        if (add_en) begin
          acc <= acc + addend;
        end
        case (state)
          MUL0:    state <= MUL1;
          MUL1:    state <= MUL2;
          MUL2:    state <= MUL3;
          MUL3:    state <= DRAIN;
          DRAIN:   state <= DONE;
          ZERO:    state <= DONE;
          DONE: begin
            p     <= acc;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mul32_seq.sv
// Directed and random checks for mul32_seq: table of vectors with
// hand-computed products and latencies, plus kill, reset and streaming runs.
module tb_mul32_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        kill;
  logic [31:0] a;
  logic [31:0] b;
  logic        signed_a;
  logic        signed_b;
  logic        busy;
  logic        done;
  logic [63:0] p;

  int nvec = 0;
  int nmis = 0;
  int en_cnt = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sa;
    logic        sb;
    logic [63:0] exp_p;
    int          exp_lat;
  } vec_t;

  vec_t vecs[12];

  mul32_seq #(.ZERO_SKIP(1)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .kill     (kill),
    .a        (a),
    .b        (b),
    .signed_a (signed_a),
    .signed_b (signed_b),
    .busy     (busy),
    .done     (done),
    .p        (p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (dut.dsp_en) en_cnt++;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y,
                                          input logic sx, input logic sy);
    logic signed [63:0] ex;
    logic signed [63:0] ey;
    ex = sx ? {{32{x[31]}}, x} : {32'h0, x};
    ey = sy ? {{32{y[31]}}, y} : {32'h0, y};
    return ex * ey;
  endfunction

  // Apply one operation from idle and measure edges from accept to done.
  task automatic do_op(input vec_t v, input logic k, input string nm);
    int  lat;
    int  en0;
    @(negedge clk);
    a = v.a; b = v.b; signed_a = v.sa; signed_b = v.sb; start = 1'b1; kill = k;
    @(posedge clk);
    #1;
    start = 1'b0; kill = 1'b0;
    en0 = en_cnt;
    chk({nm, "_busy"}, 64'(busy), 64'd1);
    lat = -1;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = i;
        break;
      end
    end
    chk({nm, "_lat"}, 64'(lat), 64'(v.exp_lat));
    chk({nm, "_p"}, p, v.exp_p);
    chk({nm, "_busy_at_done"}, 64'(busy), 64'd0);
    if (v.exp_lat == 2) chk({nm, "_dsp_en"}, 64'(en_cnt - en0), 64'd0);
    @(posedge clk);
    #1;
    chk({nm, "_done_width"}, 64'(done), 64'd0);
  endtask

  initial begin
    logic [63:0] held;
    logic [63:0] exp;
    int          seen;
    vec_t        v;

    vecs[0]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 64'hFFFFFFFE00000001, 6};
    vecs[1]  = '{32'h80000000, 32'h80000000, 1'b1, 1'b1, 64'h4000000000000000, 6};
    vecs[2]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, 64'h0000000000000001, 6};
    vecs[3]  = '{32'hFFFFFFFE, 32'hFFFFFFFF, 1'b1, 1'b0, 64'hFFFFFFFE00000002, 6};
    vecs[4]  = '{32'h00000000, 32'h12345678, 1'b0, 1'b0, 64'h0000000000000000, 2};
    vecs[5]  = '{32'h00000003, 32'h00000005, 1'b0, 1'b0, 64'h000000000000000F, 6};
    vecs[6]  = '{32'hFFFFFFFD, 32'h00000005, 1'b1, 1'b1, 64'hFFFFFFFFFFFFFFF1, 6};
    vecs[7]  = '{32'hFFFFFFFD, 32'h00000005, 1'b0, 1'b0, 64'h00000004FFFFFFF1, 6};
    vecs[8]  = '{32'h12345678, 32'h00000000, 1'b1, 1'b1, 64'h0000000000000000, 2};
    vecs[9]  = '{32'h00010000, 32'h00010000, 1'b0, 1'b0, 64'h0000000100000000, 6};
    vecs[10] = '{32'h80000000, 32'h00000001, 1'b1, 1'b0, 64'hFFFFFFFF80000000, 6};
    vecs[11] = '{32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b1, 64'hFFFFFFFF80000000, 6};

    rst_n = 1'b0; start = 1'b0; kill = 1'b0;
    a = '0; b = '0; signed_a = 1'b0; signed_b = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_p", p, 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) do_op(vecs[i], 1'b0, $sformatf("vec%0d", i));

    // kill together with start in IDLE: start wins
    v = '{32'h00000007, 32'h00000009, 1'b0, 1'b0, 64'd63, 6};
    do_op(v, 1'b1, "kill_start_idle");

    // kill while in DONE: result already committed, done still pulses
    @(negedge clk);
    a = 32'h11111111; b = 32'h00000010; signed_a = 1'b0; signed_b = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #1 kill = 1'b1;
    @(posedge clk);
    #1 kill = 1'b0;
    chk("kill_done_pulse", 64'(done), 64'd1);
    chk("kill_done_p", p, 64'h0000000111111110);
    held = p;

    // kill in MUL2: abort, no done, p unchanged
    @(negedge clk);
    a = 32'h00000007; b = 32'h00000009; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #1 kill = 1'b1;
    @(posedge clk);
    #1 kill = 1'b0;
    chk("kill_mul2_busy", 64'(busy), 64'd0);
    seen = 0;
    repeat (8) begin
      @(posedge clk);
      #1 if (done) seen++;
    end
    chk("kill_mul2_no_done", 64'(seen), 64'd0);
    chk("kill_mul2_p_held", p, held);
    v = '{32'h00000003, 32'h00000005, 1'b0, 1'b0, 64'd15, 6};
    do_op(v, 1'b0, "after_kill");

    // asynchronous reset mid-operation
    @(negedge clk);
    a = 32'h00001234; b = 32'h00005678; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_p", p, 64'd0);
    @(negedge clk) rst_n = 1'b1;
    seen = 0;
    repeat (8) begin
      @(posedge clk);
      #1 if (done) seen++;
    end
    chk("midrst_no_done", 64'(seen), 64'd0);

    // start held high: accepted every 7 edges, operands during busy ignored
    @(negedge clk);
    a = $urandom | 32'h1; b = $urandom | 32'h100;
    signed_a = 1'($urandom); signed_b = 1'($urandom);
    start = 1'b1;
    for (int op = 0; op < 1000; op++) begin
      exp = ref_mul(a, b, signed_a, signed_b);
      @(posedge clk);
      seen = 0;
      repeat (6) begin
        @(negedge clk);
        if (done) seen++;
        a = $urandom; b = $urandom;
        signed_a = 1'($urandom); signed_b = 1'($urandom);
      end
      @(negedge clk);
      chk($sformatf("stream%0d_early_done", op), 64'(seen), 64'd0);
      chk($sformatf("stream%0d_done", op), 64'(done), 64'd1);
      chk($sformatf("stream%0d_p", op), p, exp);
      a = $urandom; b = $urandom;
      if (a == '0) a = 32'h1;
      if (b == '0) b = 32'h1;
      signed_a = 1'($urandom); signed_b = 1'($urandom);
    end
    start = 1'b0;
    repeat (10) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
